usbhid_report_arbiter: RTL and testbench

Shares one HID report sink (hex decoder / OLED path) between up to four USB HID host instances (US2/US3/US4 ports), each running on the same USB clock. It buffers the latest report from each port and issues them to a single output in round-robin or fixed-port order. A per-port watchdog detects silent ports and drives that port's `bus_reset` to restart enumeration. It sits between the `UsbHostHid` instances and the display/report consumer, in the `clk_usb` domain.

---
 rtl/usbhid_report_arbiter_if.sv | 30 +++
 rtl/usbhid_report_arbiter.sv | 154 +++++++++++++++
 tb/tb_usbhid_report_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/usbhid_report_arbiter_if.sv
// HID report arbiter bus: per-port report inputs, selection
// controls, the single issued-report output and watchdog status.
interface usbhid_report_arbiter_if #(
    parameter int C_ports        = 3,
    parameter int C_report_bytes = 20
);
    localparam int R = C_report_bytes * 8;

    logic [C_ports*R-1:0] hid_report;
    logic [C_ports-1:0]   hid_valid;
    logic                 sel_mode;
    logic [1:0]           sel_port;
    logic [R-1:0]         out_report;
    logic [1:0]           out_port;
    logic                 out_valid;
    logic [C_ports-1:0]   bus_reset;
    logic [C_ports-1:0]   port_alive;

    modport master (
        output hid_report, hid_valid, sel_mode, sel_port,
        input  out_report, out_port, out_valid,
        input  bus_reset, port_alive
    );

    modport slave (
        input  hid_report, hid_valid, sel_mode, sel_port,
        output out_report, out_port, out_valid,
        output bus_reset, port_alive
    );
endinterface

// File: rtl/usbhid_report_arbiter.sv
// Latest-report buffer and round-robin/fixed arbiter for up to four
// USB HID host ports, with a per-port silence watchdog and bus reset.
module usbhid_report_arbiter #(
    parameter int C_ports          = 3,
    parameter int C_report_bytes   = 20,
    parameter int C_timeout_cycles = 6000000,
    parameter int C_reset_cycles   = 60000
) (
    input logic                    clk,
    input logic                    resetn,
    usbhid_report_arbiter_if.slave bus
);
    localparam int R    = C_report_bytes * 8;
    localparam int CMAX = (C_timeout_cycles > C_reset_cycles)
                        ? C_timeout_cycles : C_reset_cycles;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(C_timeout_cycles - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(C_reset_cycles - 1);
    localparam logic [1:0]    LAST_INI = 2'(C_ports - 1);

    typedef enum logic [1:0] {WAIT, ALIVE, BUSRST} wd_state_e;

    wd_state_e          st_q   [C_ports];
    wd_state_e          st_d   [C_ports];
    logic [CW-1:0]      cnt_q  [C_ports];
    logic [CW-1:0]      cnt_d  [C_ports];
    logic [R-1:0]       slot_q [C_ports];
    logic [R-1:0]       slot_d [C_ports];
    logic [C_ports-1:0] pending_q, pending_d;
    logic [C_ports-1:0] acc, enter_rst, elig;
    logic [1:0]         last_q, last_d;
    logic [R-1:0]       out_report_q, out_report_d;
    logic [1:0]         out_port_q, out_port_d;
    logic               out_valid_q, out_valid_d;
    logic               gnt_hit;
    logic [1:0]         gnt_idx;

    // Watchdog next state; a port in BUSRST ignores its strobe.
    always_comb begin
        for (int i = 0; i < C_ports; i++) begin
            st_d[i]      = st_q[i];
            cnt_d[i]     = cnt_q[i] + 1'b1;
            acc[i]       = bus.hid_valid[i] && (st_q[i] != BUSRST);
            enter_rst[i] = 1'b0;
            unique case (st_q[i])
                WAIT, ALIVE: begin
                    if (acc[i]) begin
                        st_d[i]  = ALIVE;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == TO_LAST) begin
                        st_d[i]      = BUSRST;
                        cnt_d[i]     = '0;
                        enter_rst[i] = 1'b1;
                    end
                end
                BUSRST: begin
                    if (cnt_q[i] == RST_LAST) begin
                        st_d[i]  = WAIT;
                        cnt_d[i] = '0;
                    end
                end
                default: begin
                    st_d[i]  = WAIT;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Grant search: first eligible port after the last grant, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_hit = 1'b0;
        gnt_idx = last_q;
        for (int i = 0; i < C_ports; i++) begin
            elig[i] = pending_q[i]
                    && (!bus.sel_mode || bus.sel_port == 2'(i));
        end
        for (int k = 1; k <= C_ports; k++) begin
            idx = (int'(last_q) + k) % C_ports;
            if (!gnt_hit && elig[idx]) begin
                gnt_hit = 1'b1;
                gnt_idx = 2'(idx);
            end
        end
    end

    // Issue path and slot capture; capture overrides a same-cycle grant.
    always_comb begin
        pending_d    = pending_q;
        last_d       = last_q;
        out_valid_d  = 1'b0;
        out_report_d = out_report_q;
        out_port_d   = out_port_q;
        if (gnt_hit) begin
            pending_d[gnt_idx] = 1'b0;
            last_d             = gnt_idx;
            out_valid_d        = 1'b1;
            out_report_d       = slot_q[gnt_idx];
            out_port_d         = gnt_idx;
        end
        for (int i = 0; i < C_ports; i++) begin
            slot_d[i] = slot_q[i];
            if (acc[i]) begin
                slot_d[i]    = bus.hid_report[i*R +: R];
                pending_d[i] = 1'b1;
            end
            if (enter_rst[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < C_ports; i++) begin
                st_q[i]   <= WAIT;
                cnt_q[i]  <= '0;
                slot_q[i] <= '0;
            end
            pending_q    <= '0;
            last_q       <= LAST_INI;
            out_valid_q  <= 1'b0;
            out_report_q <= '0;
            out_port_q   <= '0;
        end else begin
            for (int i = 0; i < C_ports; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                slot_q[i] <= slot_d[i];
            end
            pending_q    <= pending_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_report_q <= out_report_d;
            out_port_q   <= out_port_d;
        end
    end

    // Status outputs decode the registered watchdog state.
    always_comb begin
        for (int i = 0; i < C_ports; i++) begin
            bus.bus_reset[i]  = (st_q[i] == BUSRST);
            bus.port_alive[i] = (st_q[i] == ALIVE);
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_report = out_report_q;
    assign bus.out_port   = out_port_q;
endmodule

// File: tb/tb_usbhid_report_arbiter.sv
// Directed bench for usbhid_report_arbiter: issue order, fairness,
// fixed-port mode, watchdog timing and asynchronous reset.
module tb_usbhid_report_arbiter;
    localparam int NP = 3;
    localparam int RB = 8;
    localparam int TO = 100;
    localparam int RC = 10;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_run  = 0;
    int   n_fail = 0;

    localparam logic [63:0] D1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] DA  = 64'hA0A0_0000_1111_0000;
    localparam logic [63:0] DB  = 64'hB1B1_2222_3333_0001;
    localparam logic [63:0] DC  = 64'hC2C2_4444_5555_0002;

    usbhid_report_arbiter_if #(.C_ports(NP), .C_report_bytes(RB)) bus();

    usbhid_report_arbiter #(
        .C_ports(NP),
        .C_report_bytes(RB),
        .C_timeout_cycles(TO),
        .C_reset_cycles(RC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v);
        bus.hid_valid = v;
        tick();
        bus.hid_valid = '0;
    endtask

    task automatic do_reset();
        bus.hid_valid  = '0;
        bus.hid_report = '0;
        bus.sel_mode   = 1'b0;
        bus.sel_port   = 2'd0;
        resetn         = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        // reset state
        do_reset();
        resetn = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_port", bus.out_port, 0);
        check("rst_data", bus.out_report, 0);
        check("rst_busrst", bus.bus_reset, 0);
        check("rst_alive", bus.port_alive, 0);

        // single report on port 1
        do_reset();
        bus.hid_report[64 +: 64] = D1;
        send(3'b010);
        check("t1_alive", bus.port_alive, 3'b010);
        check("t1_v_n1", bus.out_valid, 0);
        tick();
        check("t1_v_n2", bus.out_valid, 1);
        check("t1_port", bus.out_port, 1);
        check("t1_data", bus.out_report, D1);
        tick();
        check("t1_v_n3", bus.out_valid, 0);
        check("t1_hold", bus.out_report, D1);

        // simultaneous capture on all ports
        do_reset();
        bus.hid_report = {DC, DB, DA};
        send(3'b111);
        check("t2_v_n1", bus.out_valid, 0);
        tick();
        check("t2_v0", bus.out_valid, 1);
        check("t2_p0", bus.out_port, 0);
        check("t2_d0", bus.out_report, DA);
        tick();
        check("t2_v1", bus.out_valid, 1);
        check("t2_p1", bus.out_port, 1);
        check("t2_d1", bus.out_report, DB);
        tick();
        check("t2_v2", bus.out_valid, 1);
        check("t2_p2", bus.out_port, 2);
        check("t2_d2", bus.out_report, DC);
        tick();
        check("t2_v3", bus.out_valid, 0);

        // fairness: port 0 streaming, port 2 once
        do_reset();
        bus.hid_report[0 +: 64] = DA;
        bus.hid_valid = 3'b001;
        repeat (4) tick();
        bus.hid_report[128 +: 64] = DC;
        bus.hid_valid = 3'b101;
        tick();
        bus.hid_valid = 3'b001;
        check("t3_p_m1", bus.out_port, 0);
        tick();
        check("t3_v_m2", bus.out_valid, 1);
        check("t3_p_m2", bus.out_port, 2);
        check("t3_d_m2", bus.out_report, DC);
        tick();
        check("t3_v_m3", bus.out_valid, 1);
        check("t3_p_m3", bus.out_port, 0);
        bus.hid_valid = '0;

        // watchdog on port 1
        do_reset();
        send(3'b010);
        check("t4_alive", bus.port_alive[1], 1);
        repeat (99) tick();
        check("t4_rst_pre", bus.bus_reset[1], 0);
        check("t4_alive_pre", bus.port_alive[1], 1);
        tick();
        check("t4_rst_on", bus.bus_reset[1], 1);
        check("t4_alive_off", bus.port_alive[1], 0);
        repeat (4) tick();
        send(3'b010);
        check("t4_ign_v1", bus.out_valid, 0);
        check("t4_ign_al", bus.port_alive[1], 0);
        tick();
        check("t4_ign_v2", bus.out_valid, 0);
        repeat (3) tick();
        check("t4_rst_last", bus.bus_reset[1], 1);
        tick();
        check("t4_rst_end", bus.bus_reset[1], 0);
        check("t4_wait", bus.port_alive[1], 0);
        tick();
        check("t4_ign_v3", bus.out_valid, 0);

        // fixed mode, then back to round-robin
        do_reset();
        bus.sel_mode   = 1'b1;
        bus.sel_port   = 2'd2;
        bus.hid_report = {DC, DB, DA};
        send(3'b101);
        tick();
        check("t5_v", bus.out_valid, 1);
        check("t5_p", bus.out_port, 2);
        check("t5_d", bus.out_report, DC);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_hold", bus.out_valid, 0);
        end
        bus.sel_mode = 1'b0;
        tick();
        check("t5_rr_v", bus.out_valid, 1);
        check("t5_rr_p", bus.out_port, 0);
        check("t5_rr_d", bus.out_report, DA);
        tick();
        check("t5_rr_end", bus.out_valid, 0);

        // fixed mode with out-of-range port
        do_reset();
        bus.sel_mode   = 1'b1;
        bus.sel_port   = 2'd3;
        bus.hid_report = {DC, DB, DA};
        send(3'b001);
        tick();
        check("t5b_none1", bus.out_valid, 0);
        tick();
        check("t5b_none2", bus.out_valid, 0);
        bus.sel_port = 2'd0;
        tick();
        check("t5b_v", bus.out_valid, 1);
        check("t5b_p", bus.out_port, 0);

        // asynchronous reset mid-BUSRST
        do_reset();
        send(3'b111);
        repeat (100) tick();
        check("t6_busrst", bus.bus_reset, 3'b111);
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_br", bus.bus_reset, 0);
        check("t6_rst_ov", bus.out_valid, 0);
        check("t6_rst_al", bus.port_alive, 0);
        tick();
        resetn = 1'b1;

        // asynchronous reset while a strobe is registered
        bus.hid_report = {DC, DB, DA};
        send(3'b010);
        tick();
        check("t6_pre_v", bus.out_valid, 1);
        check("t6_pre_al", bus.port_alive[1], 1);
        #2 resetn = 1'b0;
        #1;
        check("t6_ov0", bus.out_valid, 0);
        check("t6_al0", bus.port_alive, 0);
        check("t6_d0", bus.out_report, 0);
        tick();
        resetn = 1'b1;
        send(3'b101);
        tick();
        check("t6_first_v", bus.out_valid, 1);
        check("t6_first_p", bus.out_port, 0);
        tick();
        check("t6_next_p", bus.out_port, 2);
        check("t6_next_d", bus.out_report, DC);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
